logo_motion_ctrl: RTL and testbench
===================================

LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

Interface
REQ-001 Parameter LOGO_SIZE, default 128, logo edge length in pixels.
REQ-002 Parameter DISPLAY_WIDTH, default 640, visible width in pixels.
REQ-003 Parameter DISPLAY_HEIGHT, default 480, visible height in pixels.
REQ-004 Parameter START_X, default 200, reset logo_left.
REQ-005 Parameter START_Y, default 200, reset logo_top.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 vpos  input  10  current scanline from the sync generator.
REQ-009 pause  input  1  high freezes motion.
REQ-010 speed  input  2  step size minus one (1..4 px/frame).
REQ-011 logo_left  output  10  logo X origin.
REQ-012 logo_top  output  10  logo Y origin.
REQ-013 dir_x  output  1  1 = moving right.
REQ-014 dir_y  output  1  1 = moving down.
REQ-015 color_index  output  3  palette selector.
REQ-016 bounce  output  1  one-cycle pulse when any wall is hit.
REQ-017 busy  output  1  high while an update is in progress.

Function
REQ-018 Frame edge: vpos==0 and registered prev_vpos!=0; prev_vpos updates every cycle.
REQ-019 FSM states: IDLE, MOVE_X, MOVE_Y, COMMIT; busy=1 outside IDLE.
REQ-020 IDLE->MOVE_X on a frame edge with pause=0; pause=1 or no frame edge -> remain in IDLE with no output change.
REQ-021 MOVE_X: step=speed+1; MAX_X=DISPLAY_WIDTH-LOGO_SIZE. Left (dir_x=0): if shadow_x<=step, result 0, dir 1, bounce; else shadow_x-step. Right: if shadow_x+step>=MAX_X, result MAX_X, dir 0, bounce; else shadow_x+step.
REQ-022 MOVE_Y: same rule with MAX_Y=DISPLAY_HEIGHT-LOGO_SIZE, dir_y and shadow_y.
REQ-023 Arithmetic is 10-bit and clamped; no wrap-around is permitted, and positions never leave 0..MAX.
REQ-024 COMMIT: logo_left, logo_top, dir_x and dir_y update atomically from the shadows; color_index += number of axes bounced this frame (0, 1 or 2, modulo 8); bounce=1 for this cycle only if at least one axis bounced; next state IDLE.
REQ-025 Latency: outputs change exactly 3 cycles after the cycle in which the frame edge is seen; at most one update per frame.
REQ-026 A frame edge while busy=1 is ignored.
REQ-027 pause sampled only in IDLE; a change during MOVE_X, MOVE_Y or COMMIT does not abort the update.

Reset
REQ-028 rst_n=0: state IDLE, logo_left=START_X, logo_top=START_Y, dir_x=1, dir_y=0, color_index=0, bounce=0, busy=0, prev_vpos=0, shadows equal outputs.
REQ-029 Reset mid-update discards the shadow values; no partial update is visible.

Configuration
REQ-030 Macro MOTION_SPEED_EN: when defined, step=speed+1; when undefined, step is fixed at 1 and speed is ignored.

Structure
REQ-031 Shared package vga_pkg: FSM state enum, default geometry constants (640, 480, 128), and the MAX_X/MAX_Y derivation.
REQ-032 One sub-module, axis_step, computes next position, next direction and hit for one axis; it is instantiated once and time-shared across MOVE_X and MOVE_Y.

Verification
REQ-033 Reset then a vpos 524->0 transition, speed=0 -> after 3 cycles left=201, top=199, bounce=0, color_index=0.
REQ-034 Force left=511, dir_x=1, speed=0, frame edge -> left=512, dir_x=0, bounce pulse of 1 cycle, color_index+1.
REQ-035 Corner: left=2, top=2, dir_x=0, dir_y=0, speed=3, frame edge -> left=0, top=0, both dirs 1, color_index+2.
REQ-036 pause=1 across 3 frame edges -> outputs unchanged, busy stays 0.
REQ-037 rst_n=0 asserted in MOVE_Y -> next cycle all outputs at reset values, state IDLE.
REQ-038 Build without MOTION_SPEED_EN, speed=3 -> step of 1 px/frame.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared geometry constants, FSM state encoding and wall-limit helper for the logo motion block
// Contents:
//   POS_W                      position width in bits (10)
//   DEF_DISPLAY_WIDTH/HEIGHT   default visible area (640 x 480)
//   DEF_LOGO_SIZE              default logo edge length (128)
//   state_t / ST_*             motion FSM states: IDLE, MOVE_X, MOVE_Y, COMMIT
//   axis_max()                 farthest legal origin on one axis (display - logo)
package vga_pkg;

    localparam int POS_W              = 10;
    localparam int DEF_DISPLAY_WIDTH  = 640;
    localparam int DEF_DISPLAY_HEIGHT = 480;
    localparam int DEF_LOGO_SIZE      = 128;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVE_X = 2'd1;
    localparam logic [1:0] ST_MOVE_Y = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    function automatic logic [POS_W-1:0] axis_max(input int display, input int logo);
        return POS_W'(display - logo);
    endfunction

endpackage

// File: rtl/axis_step.sv
// rtl/axis_step.sv - one-axis bounce step: next position, next direction and wall hit
// Ports:
//   pos       current position on this axis
//   dir       1 = moving toward max_pos, 0 = moving toward 0
//   max_pos   farthest legal position on this axis
//   step      step size in pixels (1..4)
//   next_pos  clamped position after the step
//   next_dir  direction after the step (flips on a wall hit)
//   hit       1 when the step reached a wall
module axis_step
    import vga_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    input  logic             dir,
    input  logic [POS_W-1:0] max_pos,
    input  logic [2:0]       step,
    output logic [POS_W-1:0] next_pos,
    output logic             next_dir,
    output logic             hit
);

    // One extra bit so the forward sum cannot wrap before it is compared.
    logic [POS_W:0] fwd_sum;

    assign fwd_sum = {1'b0, pos} + (POS_W+1)'(step);

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        hit      = 1'b0;
        if (dir) begin
            if (fwd_sum >= {1'b0, max_pos}) begin
                next_pos = max_pos;
                next_dir = 1'b0;
                hit      = 1'b1;
            end else begin
                next_pos = fwd_sum[POS_W-1:0];
            end
        end else begin
            // Test before subtracting so the result never wraps below zero.
            if (pos <= POS_W'(step)) begin
                next_pos = '0;
                next_dir = 1'b1;
                hit      = 1'b1;
            end else begin
                next_pos = pos - POS_W'(step);
            end
        end
    end

endmodule

// File: rtl/logo_motion_ctrl.sv
// rtl/logo_motion_ctrl.sv - once-per-frame bouncing logo position controller
// Optional feature macro: MOTION_SPEED_EN (defined: step = speed + 1; undefined: step fixed at 1)
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   vpos         current scanline; frame edge is vpos returning to 0
//   pause        high freezes motion (sampled in IDLE only)
//   speed        step size minus one
//   logo_left    logo X origin
//   logo_top     logo Y origin
//   dir_x        1 = moving right
//   dir_y        1 = moving down
//   color_index  palette selector, advanced by one per wall hit
//   bounce       one-cycle pulse when a frame update hit any wall
//   busy         high while an update is in flight
module logo_motion_ctrl
    import vga_pkg::*;
#(
    parameter int LOGO_SIZE      = DEF_LOGO_SIZE,
    parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
    parameter int START_X        = 200,
    parameter int START_Y        = 200
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       vpos,
    input  logic             pause,
    input  logic [1:0]       speed,
    output logic [9:0]       logo_left,
    output logic [9:0]       logo_top,
    output logic             dir_x,
    output logic             dir_y,
    output logic [2:0]       color_index,
    output logic             bounce,
    output logic             busy
);

    localparam logic [POS_W-1:0] MAX_X   = axis_max(DISPLAY_WIDTH, LOGO_SIZE);
    localparam logic [POS_W-1:0] MAX_Y   = axis_max(DISPLAY_HEIGHT, LOGO_SIZE);
    localparam logic [POS_W-1:0] START_L = POS_W'(START_X);
    localparam logic [POS_W-1:0] START_T = POS_W'(START_Y);

    state_t           state;
    logic [POS_W-1:0] prev_vpos;
    logic [POS_W-1:0] shadow_x;
    logic [POS_W-1:0] shadow_y;
    logic             shadow_dir_x;
    logic             shadow_dir_y;
    logic             hit_x;
    logic             hit_y;
    logic             frame_edge;
    logic [2:0]       step;

    logic [POS_W-1:0] ax_pos;
    logic             ax_dir;
    logic [POS_W-1:0] ax_max;
    logic [POS_W-1:0] ax_next_pos;
    logic             ax_next_dir;
    logic             ax_hit;

`ifdef MOTION_SPEED_EN
    assign step = {1'b0, speed} + 3'd1;
`else
    logic unused_speed;
    assign unused_speed = ^speed;
    assign step         = 3'd1;
`endif

    assign frame_edge = (vpos == '0) && (prev_vpos != '0);
    assign busy       = (state != ST_IDLE);

    // The single stepper works on X during MOVE_X and on Y otherwise; its
    // result is only captured in MOVE_X / MOVE_Y.
    always_comb begin
        ax_pos = shadow_y;
        ax_dir = shadow_dir_y;
        ax_max = MAX_Y;
        if (state == ST_MOVE_X) begin
            ax_pos = shadow_x;
            ax_dir = shadow_dir_x;
            ax_max = MAX_X;
        end
    end

    axis_step u_axis_step (
        .pos      (ax_pos),
        .dir      (ax_dir),
        .max_pos  (ax_max),
        .step     (step),
        .next_pos (ax_next_pos),
        .next_dir (ax_next_dir),
        .hit      (ax_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            prev_vpos    <= '0;
            shadow_x     <= START_L;
            shadow_y     <= START_T;
            shadow_dir_x <= 1'b1;
            shadow_dir_y <= 1'b0;
            hit_x        <= 1'b0;
            hit_y        <= 1'b0;
            logo_left    <= START_L;
            logo_top     <= START_T;
            dir_x        <= 1'b1;
            dir_y        <= 1'b0;
            color_index  <= '0;
            bounce       <= 1'b0;
        end else begin
            prev_vpos <= vpos;
            bounce    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_edge && !pause) begin
                        state <= ST_MOVE_X;
                    end
                end
                ST_MOVE_X: begin
                    shadow_x     <= ax_next_pos;
                    shadow_dir_x <= ax_next_dir;
                    hit_x        <= ax_hit;
                    state        <= ST_MOVE_Y;
                end
                ST_MOVE_Y: begin
                    shadow_y     <= ax_next_pos;
                    shadow_dir_y <= ax_next_dir;
                    hit_y        <= ax_hit;
                    state        <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // All visible outputs move together so a reader never sees
                    // X updated without Y.
                    logo_left   <= shadow_x;
                    logo_top    <= shadow_y;
                    dir_x       <= shadow_dir_x;
                    dir_y       <= shadow_dir_y;
                    color_index <= color_index + 3'(hit_x) + 3'(hit_y);
                    bounce      <= hit_x | hit_y;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// tb/tb_logo_motion_ctrl.sv - directed self-checking bench for logo_motion_ctrl
module tb_logo_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] vpos;
    logic       pause;
    logic [1:0] speed;

    logic [9:0] a_left, a_top, c_left, c_top;
    logic       a_dir_x, a_dir_y, a_bounce, a_busy;
    logic       c_dir_x, c_dir_y, c_bounce, c_busy;
    logic [2:0] a_color, c_color;

    logic [24:0] a_obs, c_obs;
    assign a_obs = {a_left, a_top, a_dir_x, a_dir_y, a_color};
    assign c_obs = {c_left, c_top, c_dir_x, c_dir_y, c_color};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Default geometry: starts at (200,200), moving right and up.
    logo_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .vpos(vpos), .pause(pause), .speed(speed),
        .logo_left(a_left), .logo_top(a_top), .dir_x(a_dir_x), .dir_y(a_dir_y),
        .color_index(a_color), .bounce(a_bounce), .busy(a_busy)
    );

    // Starts one pixel from the right wall and one from the top: first frame hits both.
    logo_motion_ctrl #(.START_X(511), .START_Y(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .vpos(vpos), .pause(pause), .speed(speed),
        .logo_left(c_left), .logo_top(c_top), .dir_x(c_dir_x), .dir_y(c_dir_y),
        .color_index(c_color), .bounce(c_bounce), .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vpos  = 10'd0;
        pause = 1'b0;
        speed = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Leaves vpos at 0 right after a nonzero line: the edge is seen before the next posedge.
    task automatic frame_edge();
        vpos = 10'd524;
        tick();
        vpos = 10'd0;
    endtask

    task automatic run_frame();
        frame_edge();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (a_obs !== {10'd200, 10'd200, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", a_obs, {10'd200, 10'd200, 1'b1, 1'b0, 3'd0});
        end
        checks++;
        if ({a_bounce, a_busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_bounce_busy got=%b exp=00", {a_bounce, a_busy});
        end
        checks++;
        if (c_obs !== {10'd511, 10'd1, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state_c got=%h exp=%h", c_obs, {10'd511, 10'd1, 1'b1, 1'b0, 3'd0});
        end
    endtask

    task automatic test_first_frame();
        frame_edge();
        tick();
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_move_x got=%b exp=1", a_busy);
        end
        tick();
        tick();
        checks++;
        if ({a_left, a_top, a_busy} !== {10'd200, 10'd200, 1'b1}) begin
            errors++;
            $display("FAIL latency_early got=%0d,%0d,%b exp=200,200,1", a_left, a_top, a_busy);
        end
        tick();
        checks++;
        if (a_obs !== {10'd201, 10'd199, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL first_frame got=%h exp=%h", a_obs, {10'd201, 10'd199, 1'b1, 1'b0, 3'd0});
        end
        checks++;
        if ({a_bounce, a_busy} !== 2'b00) begin
            errors++;
            $display("FAIL first_frame_bounce_busy got=%b exp=00", {a_bounce, a_busy});
        end
        checks++;
        if (c_obs !== {10'd512, 10'd0, 1'b0, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL corner_state got=%h exp=%h", c_obs, {10'd512, 10'd0, 1'b0, 1'b1, 3'd2});
        end
        checks++;
        if (c_bounce !== 1'b1) begin
            errors++;
            $display("FAIL corner_bounce got=%b exp=1", c_bounce);
        end
        tick();
        checks++;
        if (c_bounce !== 1'b0) begin
            errors++;
            $display("FAIL corner_bounce_width got=%b exp=0", c_bounce);
        end
    endtask

    task automatic test_pause();
        int busy_seen;
        busy_seen = 0;
        pause = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame_edge();
            for (int c = 0; c < 4; c++) begin
                tick();
                if (a_busy !== 1'b0) busy_seen++;
            end
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL pause_busy got=%0d busy cycles exp=0", busy_seen);
        end
        checks++;
        if (a_obs !== {10'd201, 10'd199, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL pause_hold got=%h exp=%h", a_obs, {10'd201, 10'd199, 1'b1, 1'b0, 3'd0});
        end
        pause = 1'b0;
    endtask

    task automatic test_pause_mid_update();
        frame_edge();
        tick();
        pause = 1'b1;
        repeat (3) tick();
        checks++;
        if ({a_left, a_top} !== {10'd202, 10'd198}) begin
            errors++;
            $display("FAIL pause_mid_update got=%0d,%0d exp=202,198", a_left, a_top);
        end
        pause = 1'b0;
    endtask

    task automatic test_edge_while_busy();
        frame_edge();
        tick();
        vpos = 10'd5;
        tick();
        vpos = 10'd0;
        tick();
        tick();
        checks++;
        if ({a_left, a_top} !== {10'd203, 10'd197}) begin
            errors++;
            $display("FAIL busy_edge_update got=%0d,%0d exp=203,197", a_left, a_top);
        end
        repeat (5) tick();
        checks++;
        if ({a_left, a_top, a_busy} !== {10'd203, 10'd197, 1'b0}) begin
            errors++;
            $display("FAIL busy_edge_ignored got=%0d,%0d,%b exp=203,197,0", a_left, a_top, a_busy);
        end
    endtask

    task automatic test_reset_mid_update();
        frame_edge();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (a_obs !== {10'd200, 10'd200, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", a_obs, {10'd200, 10'd200, 1'b1, 1'b0, 3'd0});
        end
        checks++;
        if ({a_bounce, a_busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_bounce_busy got=%b exp=00", {a_bounce, a_busy});
        end
        checks++;
        if (c_obs !== {10'd511, 10'd1, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid_c got=%h exp=%h", c_obs, {10'd511, 10'd1, 1'b1, 1'b0, 3'd0});
        end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if ({a_left, a_top, a_busy} !== {10'd200, 10'd200, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_no_partial got=%0d,%0d,%b exp=200,200,0", a_left, a_top, a_busy);
        end
    endtask

    task automatic test_walls();
        do_reset();
        for (int f = 1; f <= 313; f++) begin
            run_frame();
            if (f == 199) begin
                checks++;
                if ({a_top, a_dir_y, a_bounce} !== {10'd1, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL top_near_wall got=%0d,%b,%b exp=1,0,0", a_top, a_dir_y, a_bounce);
                end
            end
            if (f == 200) begin
                checks++;
                if (a_obs !== {10'd400, 10'd0, 1'b1, 1'b1, 3'd1}) begin
                    errors++;
                    $display("FAIL top_wall got=%h exp=%h", a_obs, {10'd400, 10'd0, 1'b1, 1'b1, 3'd1});
                end
                checks++;
                if (a_bounce !== 1'b1) begin
                    errors++;
                    $display("FAIL top_wall_bounce got=%b exp=1", a_bounce);
                end
                tick();
                checks++;
                if (a_bounce !== 1'b0) begin
                    errors++;
                    $display("FAIL top_wall_bounce_width got=%b exp=0", a_bounce);
                end
            end
            if (f == 311) begin
                checks++;
                if (a_obs !== {10'd511, 10'd111, 1'b1, 1'b1, 3'd1}) begin
                    errors++;
                    $display("FAIL right_near_wall got=%h exp=%h", a_obs, {10'd511, 10'd111, 1'b1, 1'b1, 3'd1});
                end
            end
            if (f == 312) begin
                checks++;
                if (a_obs !== {10'd512, 10'd112, 1'b0, 1'b1, 3'd2}) begin
                    errors++;
                    $display("FAIL right_wall got=%h exp=%h", a_obs, {10'd512, 10'd112, 1'b0, 1'b1, 3'd2});
                end
                checks++;
                if (a_bounce !== 1'b1) begin
                    errors++;
                    $display("FAIL right_wall_bounce got=%b exp=1", a_bounce);
                end
            end
            if (f == 313) begin
                checks++;
                if ({a_obs, a_bounce} !== {10'd511, 10'd113, 1'b0, 1'b1, 3'd2, 1'b0}) begin
                    errors++;
                    $display("FAIL after_right_wall got=%h,%b exp=%h,0", a_obs, a_bounce,
                             {10'd511, 10'd113, 1'b0, 1'b1, 3'd2});
                end
            end
        end
    endtask

    task automatic test_speed();
        logic [9:0] exp_left;
        logic [9:0] exp_top;
`ifdef MOTION_SPEED_EN
        exp_left = 10'd204;
        exp_top  = 10'd196;
`else
        exp_left = 10'd201;
        exp_top  = 10'd199;
`endif
        do_reset();
        speed = 2'd3;
        run_frame();
        checks++;
        if ({a_left, a_top} !== {exp_left, exp_top}) begin
            errors++;
            $display("FAIL speed_step got=%0d,%0d exp=%0d,%0d", a_left, a_top, exp_left, exp_top);
        end
        checks++;
        if (c_obs !== {10'd512, 10'd0, 1'b0, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL speed_corner got=%h exp=%h", c_obs, {10'd512, 10'd0, 1'b0, 1'b1, 3'd2});
        end
        speed = 2'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        vpos  = 10'd0;
        pause = 1'b0;
        speed = 2'd0;
        test_reset();
        test_first_frame();
        test_pause();
        test_pause_mid_update();
        test_edge_while_busy();
        test_reset_mid_update();
        test_walls();
        test_speed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
